// File: rtl/sample_read_arbiter.sv
// Round-robin arbiter sharing the wave-sample BRAM read port among all sample consumers.
// Tracks in-flight reads through the fixed memory latency and routes each sample back to its requester.
module sample_read_arbiter #(
    parameter int NUM_REQ      = 6,
    parameter int WW_WIDTH     = 18,
    parameter int SAMPLE_WIDTH = 16,
    parameter int MEM_LATENCY  = 2
) (
    input  logic                                    clk_in,
    input  logic                                    rst_in,
    input  logic                                    flush_in,
    input  logic [WW_WIDTH-1:0]                     wave_width_in,
    input  logic [NUM_REQ-1:0]                      req_in,
    input  logic [NUM_REQ-1:0][WW_WIDTH-1:0]        index_in,
    output logic [NUM_REQ-1:0][SAMPLE_WIDTH-1:0]    data_out,
    output logic [NUM_REQ-1:0]                      valid_out,
    output logic                                    mem_en_out,
    output logic [WW_WIDTH-1:0]                     mem_addr_out,
    input  logic [SAMPLE_WIDTH-1:0]                 mem_data_in,
    output logic                                    busy_out
);

    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SUM_W = ID_W + 1;
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

    function automatic logic [WW_WIDTH-1:0] clamp_addr(
        input logic [WW_WIDTH-1:0] idx,
        input logic [WW_WIDTH-1:0] width
    );
        logic [WW_WIDTH-1:0] addr;
        if (width == {WW_WIDTH{1'b0}}) begin
            addr = {WW_WIDTH{1'b0}};
        end else if (idx < width) begin
            addr = idx;
        end else begin
            addr = width - WW_WIDTH'(1);
        end
        return addr;
    endfunction

    logic [NUM_REQ-1:0]                   pending_q, pending_d;
    logic [NUM_REQ-1:0][WW_WIDTH-1:0]     pend_idx_q, pend_idx_d;
    logic [ID_W-1:0]                      last_grant_q, last_grant_d;
    logic                                 mem_en_q, mem_en_d;
    logic [WW_WIDTH-1:0]                  mem_addr_q, mem_addr_d;
    logic [NUM_REQ-1:0][SAMPLE_WIDTH-1:0] data_q, data_d;
    logic [NUM_REQ-1:0]                   valid_q, valid_d;
    logic                                 busy_q, busy_d;
    // Stage 0 lines up with mem_en_out; the tag in the last stage matches mem_data_in.
    tag_t                                 tag_q [0:MEM_LATENCY];
    tag_t                                 tag_d [0:MEM_LATENCY];

    logic                                 win_found_s;
    logic [ID_W-1:0]                      win_id_s;

    // Round-robin scan starting just after the last granted requester
    always_comb begin
        logic [SUM_W-1:0] sum;
        logic [ID_W-1:0]  cand;
        win_found_s = 1'b0;
        win_id_s    = {ID_W{1'b0}};
        sum         = {SUM_W{1'b0}};
        cand        = {ID_W{1'b0}};
        for (int k = 1; k <= NUM_REQ; k++) begin
            sum = {1'b0, last_grant_q} + SUM_W'(k);
            if (sum >= SUM_W'(NUM_REQ)) begin
                sum = sum - SUM_W'(NUM_REQ);
            end else begin
                sum = sum;
            end
            cand = sum[ID_W-1:0];
            if (!win_found_s && pending_q[cand]) begin
                win_found_s = 1'b1;
                win_id_s    = cand;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Next state: flush, sample return, grant issue and request capture
    always_comb begin
        pending_d    = pending_q;
        pend_idx_d   = pend_idx_q;
        last_grant_d = last_grant_q;
        mem_en_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        data_d       = data_q;
        valid_d      = {NUM_REQ{1'b0}};
        tag_d[0]     = '0;
        for (int s = 1; s <= MEM_LATENCY; s++) begin
            tag_d[s] = tag_q[s-1];
        end

        if (flush_in) begin
            pending_d    = {NUM_REQ{1'b0}};
            last_grant_d = LAST_ID;
            for (int s = 0; s <= MEM_LATENCY; s++) begin
                tag_d[s] = '0;
            end
        end else begin
            if (tag_q[MEM_LATENCY].valid) begin
                data_d[tag_q[MEM_LATENCY].id]  = mem_data_in;
                valid_d[tag_q[MEM_LATENCY].id] = 1'b1;
            end else begin
                valid_d = {NUM_REQ{1'b0}};
            end

            if (win_found_s) begin
                mem_en_d            = 1'b1;
                mem_addr_d          = clamp_addr(pend_idx_q[win_id_s], wave_width_in);
                pending_d[win_id_s] = 1'b0;
                last_grant_d        = win_id_s;
                tag_d[0].valid      = 1'b1;
                tag_d[0].id         = win_id_s;
            end else begin
                mem_en_d = 1'b0;
            end

            // Applied after the grant clear so a same-edge re-request survives.
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_in[i]) begin
                    pending_d[i]  = 1'b1;
                    pend_idx_d[i] = index_in[i];
                end else begin
                    pend_idx_d[i] = pend_idx_d[i];
                end
            end
        end

        busy_d = |pending_d;
        for (int s = 0; s <= MEM_LATENCY; s++) begin
            busy_d = busy_d | tag_d[s].valid;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pending_q    <= {NUM_REQ{1'b0}};
            pend_idx_q   <= '0;
            last_grant_q <= LAST_ID;
            mem_en_q     <= 1'b0;
            mem_addr_q   <= {WW_WIDTH{1'b0}};
            data_q       <= '0;
            valid_q      <= {NUM_REQ{1'b0}};
            busy_q       <= 1'b0;
            for (int s = 0; s <= MEM_LATENCY; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            pending_q    <= pending_d;
            pend_idx_q   <= pend_idx_d;
            last_grant_q <= last_grant_d;
            mem_en_q     <= mem_en_d;
            mem_addr_q   <= mem_addr_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            busy_q       <= busy_d;
            for (int s = 0; s <= MEM_LATENCY; s++) begin
                tag_q[s] <= tag_d[s];
            end
        end
    end

    assign data_out     = data_q;
    assign valid_out    = valid_q;
    assign mem_en_out   = mem_en_q;
    assign mem_addr_out = mem_addr_q;
    assign busy_out     = busy_q;

endmodule
